data_bus_arbiter: RTL and testbench

- Shares the single data-side bus (`we_m`/`addr_m`/`wd_m`/`rd_m` of `simple_interconnect`) between N masters, e.g. the core data port and a future DMA engine.
- Round-robin grant per cycle; optional bus lock for read-modify-write sequences.
- Tracks the 1-cycle synchronous read latency of `ram_1port`/`rom_2port` and steers returned data to the owning master.

---
 rtl/data_bus_arbiter_pkg.sv | 26 ++
 rtl/data_bus_arbiter_if.sv | 40 ++++
 rtl/data_bus_arbiter_rr_picker.sv | 42 ++++
 rtl/data_bus_arbiter.sv | 174 +++++++++++++++++
 tb/tb_data_bus_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_bus_arbiter_pkg.sv
// Shared types and constants for the data-side bus arbiter.
package bus_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;
    localparam int PERF_CNT_W = 16;

    localparam logic [PERF_CNT_W-1:0] PERF_CNT_MAX = 16'hFFFF;

    // Saturating increment for the performance counters (never wraps).
    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] value);
        logic [PERF_CNT_W-1:0] result;
        if (value == PERF_CNT_MAX) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/data_bus_arbiter_if.sv
// Bundle of per-master request/response signals and the shared bus
// towards the interconnect.
interface data_bus_arbiter_if import bus_pkg::*; #(
    parameter int MASTERS = 2,
    parameter int ADDR_W  = BUS_ADDR_W,
    parameter int DATA_W  = BUS_DATA_W
) ();

    // Master side
    logic [MASTERS-1:0]        req;
    logic [MASTERS-1:0]        lock;
    logic [MASTERS-1:0]        we;
    logic [MASTERS*ADDR_W-1:0] addr;
    logic [MASTERS*DATA_W-1:0] wd;
    logic [MASTERS-1:0]        gnt;
    logic [MASTERS-1:0]        rvalid;
    logic [DATA_W-1:0]         rd;

    // Interconnect side
    logic                      we_m;
    logic [ADDR_W-1:0]         addr_m;
    logic [DATA_W-1:0]         wd_m;
    logic [DATA_W-1:0]         rd_m;

    modport master (
        output req, lock, we, addr, wd,
        input  gnt, rvalid, rd
    );

    modport slave (
        input  req, lock, we, addr, wd, rd_m,
        output gnt, rvalid, rd, we_m, addr_m, wd_m
    );

    modport mem (
        input  we_m, addr_m, wd_m,
        output rd_m
    );

endinterface

// File: rtl/data_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after rr_ptr,
// wrapping modulo MASTERS.
module rr_picker import bus_pkg::*; #(
    parameter  int MASTERS = 2,
    localparam int IDX_W   = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
    input  logic [MASTERS-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [MASTERS-1:0] winner_onehot,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               winner_valid
);

    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] cand_s;

    // Scan requesters starting at rr_ptr and keep the first one found.
    always_comb begin
        winner_onehot = '0;
        winner_idx    = '0;
        winner_valid  = 1'b0;
        sum_s         = '0;
        cand_s        = '0;
        for (int i = 0; i < MASTERS; i++) begin
            sum_s = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (sum_s >= (IDX_W+1)'(MASTERS)) begin
                sum_s = sum_s - (IDX_W+1)'(MASTERS);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[IDX_W-1:0];
            if (!winner_valid && req[cand_s]) begin
                winner_valid          = 1'b1;
                winner_onehot[cand_s] = 1'b1;
                winner_idx            = cand_s;
            end else begin
                winner_valid = winner_valid;
            end
        end
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Round-robin arbiter sharing the data-side bus between MASTERS requesters,
// with optional bus lock and 1-cycle read response steering.
// Optional feature: define ARB_PERF_EN to add per-master saturating
// grant/stall counters (grant_cnt, stall_cnt).
module data_bus_arbiter import bus_pkg::*; #(
    parameter int MASTERS = 2,
    parameter int ADDR_W  = BUS_ADDR_W,
    parameter int DATA_W  = BUS_DATA_W
) (
    input  logic                          clk,
    input  logic                          reset,
    data_bus_arbiter_if.slave             bus
`ifdef ARB_PERF_EN
    ,
    output logic [MASTERS*PERF_CNT_W-1:0] grant_cnt,
    output logic [MASTERS*PERF_CNT_W-1:0] stall_cnt
`endif
);

    localparam int IDX_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    arb_state_t         state_r;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [IDX_W-1:0]   owner_r;
    logic               rsp_pending_r;
    logic [IDX_W-1:0]   rsp_id_r;

    logic [MASTERS-1:0] pick_onehot_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic               pick_valid_s;
    logic [MASTERS-1:0] gnt_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic               any_gnt_s;

    logic [ADDR_W-1:0]  addr_arr_s [MASTERS];
    logic [DATA_W-1:0]  wd_arr_s   [MASTERS];

    function automatic logic [MASTERS-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [MASTERS-1:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
        return onehot;
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] nxt;
        if (idx == IDX_W'(MASTERS - 1)) begin
            nxt = '0;
        end else begin
            nxt = idx + IDX_W'(1);
        end
        return nxt;
    endfunction

    for (genvar g = 0; g < MASTERS; g++) begin : g_unpack
        assign addr_arr_s[g] = bus.addr[g*ADDR_W +: ADDR_W];
        assign wd_arr_s[g]   = bus.wd[g*DATA_W +: DATA_W];
    end

    rr_picker #(.MASTERS(MASTERS)) u_rr_picker (
        .req           (bus.req),
        .rr_ptr        (rr_ptr_r),
        .winner_onehot (pick_onehot_s),
        .winner_idx    (pick_idx_s),
        .winner_valid  (pick_valid_s)
    );

    // Same-cycle grant: round-robin in ARB, owner only while LOCKED.
    always_comb begin
        gnt_s     = '0;
        win_idx_s = '0;
        if (!reset) begin
            gnt_s = '0;
        end else begin
            case (state_r)
                ARB: begin
                    if (pick_valid_s) begin
                        gnt_s     = pick_onehot_s;
                        win_idx_s = pick_idx_s;
                    end else begin
                        gnt_s = '0;
                    end
                end
                LOCKED: begin
                    win_idx_s = owner_r;
                    if (bus.req[owner_r]) begin
                        gnt_s = idx_to_onehot(owner_r);
                    end else begin
                        gnt_s = '0;
                    end
                end
                default: begin
                    gnt_s = '0;
                end
            endcase
        end
    end

    assign any_gnt_s  = |gnt_s;
    assign bus.gnt    = gnt_s;
    assign bus.we_m   = any_gnt_s & bus.we[win_idx_s];
    assign bus.addr_m = any_gnt_s ? addr_arr_s[win_idx_s] : addr_arr_s[0];
    assign bus.wd_m   = any_gnt_s ? wd_arr_s[win_idx_s]   : wd_arr_s[0];
    assign bus.rd     = bus.rd_m;
    assign bus.rvalid = rsp_pending_r ? idx_to_onehot(rsp_id_r) : '0;

    // Arbitration FSM, round-robin pointer, lock owner and read tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ARB;
            rr_ptr_r      <= '0;
            owner_r       <= '0;
            rsp_pending_r <= 1'b0;
            rsp_id_r      <= '0;
        end else begin
            rsp_pending_r <= any_gnt_s & ~bus.we[win_idx_s];
            rsp_id_r      <= win_idx_s;
            case (state_r)
                ARB: begin
                    if (any_gnt_s) begin
                        rr_ptr_r <= next_ptr(win_idx_s);
                        if (bus.lock[win_idx_s]) begin
                            owner_r <= win_idx_s;
                            state_r <= LOCKED;
                        end else begin
                            state_r <= ARB;
                        end
                    end else begin
                        state_r <= ARB;
                    end
                end
                LOCKED: begin
                    if (bus.req[owner_r] && !bus.lock[owner_r]) begin
                        state_r <= ARB;
                    end else begin
                        state_r <= LOCKED;
                    end
                end
                default: begin
                    state_r <= ARB;
                end
            endcase
        end
    end

`ifdef ARB_PERF_EN
    logic [PERF_CNT_W-1:0] grant_cnt_r [MASTERS];
    logic [PERF_CNT_W-1:0] stall_cnt_r [MASTERS];

    for (genvar g = 0; g < MASTERS; g++) begin : g_perf
        // Per-master saturating grant and stall counters.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                grant_cnt_r[g] <= '0;
                stall_cnt_r[g] <= '0;
            end else begin
                if (gnt_s[g]) begin
                    grant_cnt_r[g] <= sat_inc(grant_cnt_r[g]);
                end else begin
                    grant_cnt_r[g] <= grant_cnt_r[g];
                end
                if (bus.req[g] && !gnt_s[g]) begin
                    stall_cnt_r[g] <= sat_inc(stall_cnt_r[g]);
                end else begin
                    stall_cnt_r[g] <= stall_cnt_r[g];
                end
            end
        end
        assign grant_cnt[g*PERF_CNT_W +: PERF_CNT_W] = grant_cnt_r[g];
        assign stall_cnt[g*PERF_CNT_W +: PERF_CNT_W] = stall_cnt_r[g];
    end
`endif

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed self-checking bench for data_bus_arbiter (2 masters) with a
// small 1-cycle-latency RAM model on the shared bus.
module tb_data_bus_arbiter;
    import bus_pkg::*;

    localparam int M  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    data_bus_arbiter_if #(.MASTERS(M), .ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef ARB_PERF_EN
    logic [M*16-1:0] grant_cnt;
    logic [M*16-1:0] stall_cnt;
`endif

    data_bus_arbiter #(.MASTERS(M), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
`ifdef ARB_PERF_EN
        ,
        .grant_cnt (grant_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    // RAM model: 16 words, synchronous read, preloaded while reset spans a clock edge.
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) mem[k] <= 32'h0;
            mem[1] <= 32'hDEADBEEF;
            mem[3] <= 32'h33333333;
        end else if (bus.we_m) begin
            mem[bus.addr_m[5:2]] <= bus.wd_m;
        end
        bus.rd_m <= mem[bus.addr_m[5:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic sel, input logic r, input logic l, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            bus.req[1] = r; bus.lock[1] = l; bus.we[1] = w;
            bus.addr[63:32] = a; bus.wd[63:32] = d;
        end else begin
            bus.req[0] = r; bus.lock[0] = l; bus.we[0] = w;
            bus.addr[31:0] = a; bus.wd[31:0] = d;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  exp_gnt [3];
    logic [1:0]  exp_rv  [3];
    logic [31:0] exp_rd  [3];

    initial begin
        exp_gnt = '{2'b10, 2'b01, 2'b10};
        exp_rv  = '{2'b01, 2'b10, 2'b01};
        exp_rd  = '{32'hDEADBEEF, 32'h33333333, 32'hDEADBEEF};

        // Reset: requests present but nothing granted
        rst_n = 1'b0;
        bus.req = 2'b11; bus.lock = 2'b00; bus.we = 2'b00;
        bus.addr = '0; bus.wd = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_we_m", 32'(bus.we_m), 32'h0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
        bus.req = 2'b00;
        rst_n = 1'b1;

        // Single read by master 0
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h1004, 32'h0);
        #2;
        chk("t1_gnt", 32'(bus.gnt), 32'h1);
        chk("t1_we_m", 32'(bus.we_m), 32'h0);
        chk("t1_addr_m", bus.addr_m, 32'h1004);
        next_cycle();
        bus.req = 2'b00;
        #2;
        chk("t1_rvalid", 32'(bus.rvalid), 32'h1);
        chk("t1_rd", bus.rd, 32'hDEADBEEF);
        chk("t1_idle_gnt", 32'(bus.gnt), 32'h0);

        // Short async reset pulse puts rr_ptr back to 0, then both masters read
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h1004, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h100C, 32'h0);
        #2;
        chk("t2_gnt0", 32'(bus.gnt), 32'h1);
        chk("t2_addr0", bus.addr_m, 32'h1004);
        chk("t2_rv0", 32'(bus.rvalid), 32'h0);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            #2;
            chk("t2_gnt", 32'(bus.gnt), 32'(exp_gnt[k]));
            chk("t2_rvalid", 32'(bus.rvalid), 32'(exp_rv[k]));
            chk("t2_rd", bus.rd, exp_rd[k]);
        end
        next_cycle();
        bus.req = 2'b00;
        #2;
        chk("t2_tail_gnt", 32'(bus.gnt), 32'h0);
        chk("t2_tail_rvalid", 32'(bus.rvalid), 32'h2);
        chk("t2_tail_rd", bus.rd, 32'h33333333);

        // Lock: master 1 locked read, then writes while master 0 waits
        next_cycle();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h1004, 32'h0);
        #2;
        chk("t3_lock_gnt", 32'(bus.gnt), 32'h2);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h100C, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h1010, 32'hA0000001);
        #2;
        chk("t3_w1_gnt", 32'(bus.gnt), 32'h2);
        chk("t3_w1_we_m", 32'(bus.we_m), 32'h1);
        chk("t3_rd_rvalid", 32'(bus.rvalid), 32'h2);
        chk("t3_rd_data", bus.rd, 32'hDEADBEEF);
        next_cycle();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h1014, 32'hA0000002);
        #2;
        chk("t3_w2_gnt", 32'(bus.gnt), 32'h2);
        chk("t3_w2_wd_m", bus.wd_m, 32'hA0000002);
        next_cycle();
        bus.req[1] = 1'b0;
        #2;
        chk("t3_drop_gnt", 32'(bus.gnt), 32'h0);
        chk("t3_drop_we_m", 32'(bus.we_m), 32'h0);
        next_cycle();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h1018, 32'hA0000003);
        #2;
        chk("t3_w3_gnt", 32'(bus.gnt), 32'h2);
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h101C, 32'hA0000004);
        #2;
        chk("t3_unlock_gnt", 32'(bus.gnt), 32'h2);
        chk("t3_unlock_we_m", 32'(bus.we_m), 32'h1);
        next_cycle();
        bus.req[1] = 1'b0;
        #2;
        chk("t3_m0_gnt", 32'(bus.gnt), 32'h1);
        chk("t3_m0_addr", bus.addr_m, 32'h100C);
        next_cycle();
        bus.req[0] = 1'b0;
        #2;
        chk("t3_m0_rvalid", 32'(bus.rvalid), 32'h1);
        chk("t3_m0_rd", bus.rd, 32'h33333333);

        // Lock without req is ignored; read back a write done under lock
        next_cycle();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h100C, 32'h0);
        #2;
        chk("t3_stray_lock_gnt", 32'(bus.gnt), 32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h100C, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h1018, 32'h0);
        #2;
        chk("t3_after_stray_gnt", 32'(bus.gnt), 32'h2);
        next_cycle();
        bus.req[1] = 1'b0;
        #2;
        chk("t3_rb_rvalid", 32'(bus.rvalid), 32'h2);
        chk("t3_rb_rd", bus.rd, 32'hA0000003);

        // Write by master 0 then read back by master 1
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h1008, 32'h5A5A5A5A);
        #2;
        chk("t4_w_gnt", 32'(bus.gnt), 32'h1);
        chk("t4_w_we_m", 32'(bus.we_m), 32'h1);
        chk("t4_w_addr", bus.addr_m, 32'h1008);
        chk("t4_w_wd", bus.wd_m, 32'h5A5A5A5A);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h1008, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h1008, 32'h0);
        #2;
        chk("t4_r_gnt", 32'(bus.gnt), 32'h2);
        chk("t4_r_we_m", 32'(bus.we_m), 32'h0);
        next_cycle();
        bus.req[1] = 1'b0;
        bus.addr[31:0] = 32'h1020;
        #2;
        chk("t4_rvalid", 32'(bus.rvalid), 32'h2);
        chk("t4_rd", bus.rd, 32'h5A5A5A5A);
        chk("t4_idle_we_m", 32'(bus.we_m), 32'h0);
        chk("t4_idle_addr", bus.addr_m, 32'h1020);

        // Async reset one cycle after a locked read by master 1
        next_cycle();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h1004, 32'h0);
        #2;
        chk("t5_lock_gnt", 32'(bus.gnt), 32'h2);
        next_cycle();
        rst_n = 1'b0;
        bus.req = 2'b00; bus.lock = 2'b00;
        #2;
        chk("t5_rst_rvalid", 32'(bus.rvalid), 32'h0);
        chk("t5_rst_gnt", 32'(bus.gnt), 32'h0);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h1004, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h100C, 32'h0);
        #1;
        chk("t5_post_gnt", 32'(bus.gnt), 32'h1);
        chk("t5_post_rvalid", 32'(bus.rvalid), 32'h0);
        next_cycle();
        #2;
        chk("t5_next_gnt", 32'(bus.gnt), 32'h2);
        chk("t5_next_rvalid", 32'(bus.rvalid), 32'h1);
        chk("t5_next_rd", bus.rd, 32'hDEADBEEF);
        next_cycle();
        bus.req = 2'b00;
        #2;
        chk("t5_last_rvalid", 32'(bus.rvalid), 32'h2);
        chk("t5_last_rd", bus.rd, 32'h33333333);

`ifdef ARB_PERF_EN
        // Counters: 10 cycles of both requesting
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        next_cycle();
        bus.req = 2'b11; bus.we = 2'b00; bus.lock = 2'b00;
        repeat (10) @(posedge clk);
        #1;
        bus.req = 2'b00;
        #2;
        chk("perf_gnt0", 32'(grant_cnt[15:0]), 32'd5);
        chk("perf_gnt1", 32'(grant_cnt[31:16]), 32'd5);
        chk("perf_stall0", 32'(stall_cnt[15:0]), 32'd5);
        chk("perf_stall1", 32'(stall_cnt[31:16]), 32'd5);
        // Saturation: master 0 alone beyond 16'hFFFF grants
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        next_cycle();
        bus.req = 2'b01;
        repeat (65540) @(posedge clk);
        #1;
        bus.req = 2'b00;
        #2;
        chk("perf_sat_gnt0", 32'(grant_cnt[15:0]), 32'h0000FFFF);
        chk("perf_sat_stall0", 32'(stall_cnt[15:0]), 32'h0);
        chk("perf_sat_gnt1", 32'(grant_cnt[31:16]), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
